unreg_word_rx: RTL



---
 rtl/unreg_rx_pkg.sv | 19 +
 rtl/unreg_rx_outbuf.sv | 41 ++++
 rtl/unreg_word_rx.sv | 123 ++++++++++++
 3 files changed

// File: rtl/unreg_rx_pkg.sv
// Shared types and helpers for the serial word receiver.
// No logic of its own; imported by unreg_word_rx and unreg_rx_outbuf.
// Holds the FSM state encoding, default word width and the parity check.
package unreg_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } rx_state_t;

    localparam int DEF_WIDTH = 16;

    // Even parity: data bits plus parity bit must XOR to zero.
    function automatic logic par_ok(input logic [31:0] word, input logic par_bit);
        return ~(^{word, par_bit});
    endfunction

endpackage

// File: rtl/unreg_rx_outbuf.sv
// Single-entry valid/ready output register with sticky overrun detection.
// Latency: a load appears on m_data/m_valid one clock after the load edge.
// Backpressure: while full and not consumed, new loads are dropped and flag overrun.
module unreg_rx_outbuf #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             m_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    output logic             overrun
);

    logic has_room;
    logic drop;

    // A consume on the same edge frees the slot for the incoming word.
    assign has_room = ~m_valid | m_ready;
    assign drop     = load & ~has_room;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load && has_room) begin
                m_data  <= load_data;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            overrun <= (overrun & ~clr_err) | drop;
        end
    end

endmodule

// File: rtl/unreg_word_rx.sv
// Serial-to-parallel word receiver, MSB first; optional parity via UNREG_WORD_RX_PARITY_EN.
// Latency: word valid one clock after its last bit (or parity) beat.
// Backpressure: none on the serial side; a full output drops the word and sets overrun.
module unreg_word_rx
    import unreg_rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic             s_data,
    input  logic             s_start,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    output logic             par_err,
    input  logic             clr_err
);

    rx_state_t        state;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] next_word;
    logic             last_bit;
    logic             frame_fault;
    logic             load;
    logic [WIDTH-1:0] load_data;

    assign next_word   = {sreg[WIDTH-2:0], s_data};
    assign last_bit    = (count == CNT_W'(WIDTH - 1));
    assign frame_fault = s_valid & s_start & (state != IDLE);
    assign busy        = (state != IDLE);

`ifdef UNREG_WORD_RX_PARITY_EN
    logic par_fault;

    assign load      = s_valid & ~s_start & (state == PAR) & par_ok(32'(sreg), s_data);
    assign load_data = sreg;
    assign par_fault = s_valid & ~s_start & (state == PAR) & ~par_ok(32'(sreg), s_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err <= 1'b0;
        end else begin
            par_err <= (par_err & ~clr_err) | par_fault;
        end
    end
`else
    assign load      = s_valid & ~s_start & (state == SHIFT) & last_bit;
    assign load_data = next_word;
    assign par_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sreg      <= '0;
            count     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= (frame_err & ~clr_err) | frame_fault;
            if (s_valid) begin
                case (state)
                    IDLE: begin
                        if (s_start) begin
                            sreg  <= next_word;
                            count <= CNT_W'(1);
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        sreg <= next_word;
                        if (s_start) begin
                            count <= CNT_W'(1);
                        end else if (last_bit) begin
                            count <= '0;
`ifdef UNREG_WORD_RX_PARITY_EN
                            state <= PAR;
`else
                            state <= IDLE;
`endif
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                    PAR: begin
                        // A start on the parity beat opens a fresh frame.
                        if (s_start) begin
                            sreg  <= next_word;
                            count <= CNT_W'(1);
                            state <= SHIFT;
                        end else begin
                            count <= '0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    unreg_rx_outbuf #(
        .WIDTH(WIDTH)
    ) u_outbuf (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .m_ready   (m_ready),
        .clr_err   (clr_err),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .overrun   (overrun)
    );

endmodule
